// File: rtl/clk_en_mgr_pkg.sv
// Shared types and helpers for the clock-enable and reset manager.
package clk_en_mgr_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam int DIV_W_DEF    = 16;
  localparam int RST_HOLD_DEF = 16;
  localparam int DIV_W_MAX    = 32;

  // Raw ratios 0 and 1 both mean "enable every cycle".
  function automatic logic [DIV_W_MAX-1:0] eff_div_f(input logic [DIV_W_MAX-1:0] raw);
    return (raw <= 32'd1) ? 32'd1 : raw;
  endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One clock-enable channel: shadow divide ratio, down-counter and strobe decode.
module clk_en_chan
  import clk_en_mgr_pkg::*;
#(
  parameter int DIV_W    = DIV_W_DEF,
  parameter int DIV_INIT = 1
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             load_i,
  input  logic             align_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             ce_o
);

  logic [DIV_W-1:0]     shadow_q;
  logic [DIV_W-1:0]     cnt_q;
  logic [DIV_W-1:0]     cnt_d;
  logic [DIV_W-1:0]     reload_s;
  logic [DIV_W_MAX-1:0] eff_s;
  logic                 ce_q;
  logic                 ce_d;

  assign eff_s    = eff_div_f(DIV_W_MAX'(shadow_q));
  assign reload_s = DIV_W'(eff_s - 32'd1);

  // run_i is the next-cycle RUN flag, so the strobe can be registered.
  always_comb begin
    cnt_d = '0;
    if (!run_i) begin
      cnt_d = '0;
    end else if (align_i) begin
      cnt_d = '0;
    end else if (ce_q) begin
      cnt_d = reload_s;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_W'(1);
    end else begin
      cnt_d = '0;
    end
    ce_d = run_i && (cnt_d == '0);
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= DIV_W'(DIV_INIT);
      cnt_q    <= '0;
      ce_q     <= 1'b0;
    end else begin
      shadow_q <= load_i ? div_i : shadow_q;
      cnt_q    <= cnt_d;
      ce_q     <= ce_d;
    end
  end

  assign ce_o = ce_q;

endmodule

// File: rtl/clk_en_mgr.sv
// Clock-enable and reset manager: lock qualification, reset release and NUM_CH enables.
// Optional CLK_EN_MGR_PHASE_ALIGN_EN: cfg_load in RUN restarts all channels in phase.
module clk_en_mgr
  import clk_en_mgr_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = DIV_W_DEF,
  parameter int RST_HOLD = RST_HOLD_DEF,
  parameter int DIV_INIT = 1
) (
  input  logic                    clkin,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic                    cfg_load,
  output logic [NUM_CH-1:0]       ce,
  output logic                    sys_rst_n,
  output logic                    ready
);

  localparam int                HOLD_W   = $clog2(RST_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD - 1);

  state_e            state_q;
  state_e            state_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic [1:0]        sync_q;
  logic              lock_s;
  logic              run_s;
  logic              align_s;
  logic              sys_rst_n_q;
  logic              ready_q;

  assign lock_s = sync_q[1];
  assign run_s  = (state_d == RUN);

`ifdef CLK_EN_MGR_PHASE_ALIGN_EN
  assign align_s = cfg_load && (state_q == RUN);
`else
  assign align_s = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      WAIT_LOCK: begin
        hold_d  = '0;
        state_d = lock_s ? HOLD : WAIT_LOCK;
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          hold_d  = '0;
        end else if (hold_q == HOLD_MAX) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          state_d = HOLD;
          hold_d  = hold_q + HOLD_W'(1);
        end
      end
      RUN: begin
        hold_d  = '0;
        state_d = lock_s ? RUN : WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
        hold_d  = '0;
      end
    endcase
  end

  // Reset and ready are registered from the next state so they track RUN exactly.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_LOCK;
      hold_q      <= '0;
      sync_q      <= 2'b00;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      sync_q      <= {sync_q[0], pll_locked};
      sys_rst_n_q <= run_s;
      ready_q     <= run_s;
    end
  end

  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clk_en_chan #(
      .DIV_W   (DIV_W),
      .DIV_INIT(DIV_INIT)
    ) u_chan (
      .clkin  (clkin),
      .rst_n  (rst_n),
      .run_i  (run_s),
      .load_i (cfg_load),
      .align_i(align_s),
      .div_i  (div_cfg[i*DIV_W +: DIV_W]),
      .ce_o   (ce[i])
    );
  end

endmodule
